// File: rtl/audio_band_splitter.sv
// audio_band_splitter: three-band crossover built from two shift-based first-order IIR low-passes.
// Optional macro BAND_SPLIT_SAT_EN clamps band outputs instead of wrapping them.
module audio_band_splitter #(
  parameter int K_LOW = 6,
  parameter int K_HIGH = 2,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] audio_in,
  input  logic        overrun_clr,
  output logic [15:0] audio_low,
  output logic [15:0] audio_mid,
  output logic [15:0] audio_high,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);
  localparam int W = 16 + FRAC;
`ifdef BAND_SPLIT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOW, HIGH, OUT} state_t;
  state_t state;
  logic signed [15:0] x;
  logic signed [W-1:0] yl, yh, xe, yh_n;
  logic signed [W:0] dl, dh;
  logic signed [16:0] l, h, mid_w, high_w;
  function automatic logic [15:0] reduce(input logic signed [16:0] r);
    return (SAT && (r[16] != r[15])) ? {r[16], {15{~r[16]}}} : r[15:0];
  endfunction
  assign xe = {x, {FRAC{1'b0}}};
  assign dl = {xe[W-1], xe} - {yl[W-1], yl};
  assign dh = {xe[W-1], xe} - {yh[W-1], yh};
  assign yh_n = yh + W'(dh >>> K_HIGH);
  // yl is already updated in LOW; the high crossover is folded into the output register load
  assign l = 17'(yl >>> FRAC);
  assign h = 17'(yh_n >>> FRAC);
  assign mid_w = h - l;
  assign high_w = {x[15], x} - h;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      yl <= '0;
      yh <= '0;
      audio_low <= '0;
      audio_mid <= '0;
      audio_high <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun <= (sample_valid && state != IDLE) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      case (state)
        IDLE: if (sample_valid) begin
          x <= audio_in;
          state <= LOW;
        end
        LOW: begin
          yl <= yl + W'(dl >>> K_LOW);
          state <= HIGH;
        end
        HIGH: begin
          yh <= yh_n;
          audio_low <= reduce(l);
          audio_mid <= reduce(mid_w);
          audio_high <= reduce(high_w);
          out_valid <= 1'b1;
          state <= OUT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
